scan_seq_16: RTL and testbench

- Upstream driver for the 4-to-16 one-hot decoder in 16-line scanning designs such as keypads and switch matrices.
- Steps a 4-bit select index through all 16 channels with a programmable dwell per channel.
- Samples the single return line (SENSE) on each channel and assembles a 16-bit snapshot per full scan.
- Debounces snapshots across scans and reports the lowest-index active channel as a key code with a one-cycle VALID strobe.

---
 rtl/scan_seq_16_pkg.sv | 24 ++
 rtl/scan_seq_16_if.sv | 23 ++
 rtl/scan_seq_16_prio.sv | 18 +
 rtl/scan_seq_16.sv | 136 +++++++++++++
 tb/tb_scan_seq_16.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/scan_seq_16_pkg.sv
// scan_seq_16 shared types
// Channel geometry, FSM encoding, snapshot bit helper
package scan_pkg;

  localparam int CH_NUM = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [CH_NUM-1:0] put_bit(
    input logic [CH_NUM-1:0] v,
    input logic [IDX_W-1:0]  i,
    input logic              b
  );
    logic [CH_NUM-1:0] r;
    r    = v;
    r[i] = b;
    return r;
  endfunction

endpackage

// File: rtl/scan_seq_16_if.sv
// scan_seq_16 bus
// Enable/sense in, select and key report out
interface scan_seq_16_if import scan_pkg::*; ();

  logic              EN;
  logic              SENSE;
  logic [IDX_W-1:0]  SEL;
  logic [CH_NUM-1:0] SNAP;
  logic [IDX_W-1:0]  KEY;
  logic              HELD;
  logic              VALID;

  modport master (
    output EN, SENSE,
    input  SEL, SNAP, KEY, HELD, VALID
  );

  modport slave (
    input  EN, SENSE,
    output SEL, SNAP, KEY, HELD, VALID
  );

endinterface

// File: rtl/scan_seq_16_prio.sv
// prio_16_4
// Lowest-index priority encoder with any-set flag
module prio_16_4 import scan_pkg::*; (
  input  logic [CH_NUM-1:0] i_vec,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  // scan downward so the lowest set bit is written last
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = CH_NUM-1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/scan_seq_16.sv
// scan_seq_16
// 16-channel scanner with snapshot debounce and key report
module scan_seq_16 import scan_pkg::*; #(
  parameter int DWELL    = 1000,
  parameter int DEBOUNCE = 4,
  parameter int CW       = 16
) (
  input  logic         CLK,
  input  logic         RST,
  scan_seq_16_if.slave bus
);

  localparam int SW = $clog2(DEBOUNCE+1);
  localparam logic [CW-1:0] LAST = CW'(DWELL-1);
  localparam logic [SW-1:0] DB   = SW'(DEBOUNCE);

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [IDX_W-1:0]  r_sel;
  logic [CH_NUM-1:0] r_work;
  logic [CH_NUM-1:0] r_prev;
  logic [SW-1:0]     r_stable;
  logic              r_pend;
  logic [CH_NUM-1:0] r_pdata;
  logic [CH_NUM-1:0] r_snap;
  logic [IDX_W-1:0]  r_key;
  logic              r_held;
  logic              r_valid;

  logic              w_scan;
  logic              w_tick;
  logic              w_end;
  logic [CH_NUM-1:0] w_work;
  logic              w_same;
  logic [SW-1:0]     w_inc;
  logic [SW-1:0]     w_stable;
  logic              w_commit;
  logic              w_apply;
  logic [IDX_W-1:0]  w_lo;
  logic              w_any;

  assign w_scan   = (r_state == SCAN) && bus.EN;
  assign w_tick   = (r_cnt == LAST);
  assign w_end    = w_scan && w_tick && (r_sel == IDX_W'(CH_NUM-1));
  assign w_work   = put_bit(r_work, r_sel, bus.SENSE);
  assign w_same   = (w_work == r_prev);
  assign w_inc    = (r_stable == DB) ? DB : r_stable + 1'b1;
  assign w_stable = w_same ? w_inc : '0;
  assign w_commit = w_end && w_same && (w_inc == DB)
                  && (w_work != r_snap);
  assign w_apply  = r_pend && bus.EN;

  // state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // EN alone moves between idle and scanning
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.EN)  w_next = SCAN;
      SCAN:    if (!bus.EN) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // dwell, channel step, snapshot assembly and debounce history
  always_ff @(posedge CLK) begin
    if (RST || !w_scan) begin
      r_cnt    <= '0;
      r_sel    <= '0;
      r_work   <= '0;
      r_prev   <= '0;
      r_stable <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sel <= r_sel + 1'b1;
      if (w_end) begin
        r_stable <= w_stable;
        r_prev   <= w_work;
        r_work   <= '0;
      end else begin
        r_work <= w_work;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // hold a commit decision for one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend  <= 1'b0;
      r_pdata <= '0;
    end else begin
      r_pend <= w_commit;
      if (w_commit) r_pdata <= w_work;
    end
  end

  prio_16_4 u_prio (
    .i_vec (r_pdata),
    .o_idx (w_lo),
    .o_any (w_any)
  );

  // commit snapshot and report a newly pressed lowest key
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_snap  <= '0;
      r_key   <= '0;
      r_held  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_apply) begin
        r_snap <= r_pdata;
        r_held <= w_any;
        if (w_any && ((r_snap == '0) || (w_lo != r_key))) begin
          r_key   <= w_lo;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.SEL   = r_sel;
  assign bus.SNAP  = r_snap;
  assign bus.KEY   = r_key;
  assign bus.HELD  = r_held;
  assign bus.VALID = r_valid;

endmodule

// File: tb/tb_scan_seq_16.sv
// tb_scan_seq_16
// Random and directed scan stimulus against a reference model
module tb_scan_seq_16;
  import scan_pkg::*;

  localparam int DW  = 4;
  localparam int DB  = 2;
  localparam int SCN = 16*DW;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] snap;
  } ev_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        en  = 0;
  logic [15:0] keys = '0;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  ev_t q[$];

  // model state
  bit          m_on = 0;
  int          m_t = 0;
  logic [15:0] m_work = '0;
  logic [15:0] m_prev = '0;
  int          m_streak = 0;
  bit          m_pend = 0;
  logic [15:0] m_pdata = '0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_key = '0;
  bit          m_vexp = 0;

  scan_seq_16_if bus ();

  assign bus.EN    = en;
  assign bus.SENSE = keys[bus.SEL];

  scan_seq_16 #(.DWELL(DW), .DEBOUNCE(DB), .CW(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0h expected=%0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // reference: channel and debounce derived from elapsed scan time
  always @(posedge clk) begin
    int ch;
    m_vexp = 0;
    if (rst) begin
      m_on = 0; m_t = 0; m_work = 0; m_prev = 0;
      m_streak = 0; m_pend = 0; m_snap = 0; m_key = 0;
    end else if (m_on && !en) begin
      m_on = 0; m_t = 0; m_work = 0; m_prev = 0;
      m_streak = 0; m_pend = 0;
    end else if (!m_on) begin
      if (en) m_on = 1;
    end else begin
      if (m_pend) begin
        if (m_pdata != 0 &&
            (m_snap == 0 || lowest(m_pdata) != m_key)) begin
          m_key  = lowest(m_pdata);
          m_vexp = 1;
          q.push_back('{key: m_key, snap: m_pdata});
        end
        m_snap = m_pdata;
        m_pend = 0;
      end
      ch = (m_t / DW) % 16;
      if (m_t % DW == DW-1) begin
        m_work[ch] = keys[ch];
        if (ch == 15) begin
          if (m_work == m_prev) m_streak++;
          else m_streak = 0;
          if (m_streak >= DB && m_work != m_snap) begin
            m_pend  = 1;
            m_pdata = m_work;
          end
          m_prev = m_work;
          m_work = 0;
        end
      end
      m_t = (m_t + 1) % SCN;
    end
  end

  // monitor
  always @(negedge clk) begin
    ev_t e;
    chk("sel", 32'(bus.SEL), m_on ? 32'((m_t / DW) % 16) : 0);
    chk("snap", 32'(bus.SNAP), 32'(m_snap));
    chk("key", 32'(bus.KEY), 32'(m_key));
    chk("held", 32'(bus.HELD), 32'(m_snap != 0));
    chk("valid", 32'(bus.VALID), 32'(m_vexp));
    if (bus.VALID) vcount++;
    if (bus.VALID || m_vexp) begin
      if (q.size() == 0) begin
        chk("valid_unexpected", 32'(bus.VALID), 0);
      end else begin
        e = q.pop_front();
        chk("ev_key", 32'(bus.KEY), 32'(e.key));
        chk("ev_snap", 32'(bus.SNAP), 32'(e.snap));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0;
    bit found;
    rst = 1; en = 0; keys = 0;
    cyc(3);
    rst = 0;
    v0 = vcount;
    cyc(100);
    chk("idle_valid_cnt", 32'(vcount - v0), 0);
    chk("idle_sel", 32'(bus.SEL), 0);

    // single key on channel 5
    keys = 16'h0020; en = 1;
    v0 = vcount;
    cyc(5*SCN);
    chk("single_valid_cnt", 32'(vcount - v0), 1);
    chk("single_snap", 32'(bus.SNAP), 32'h0020);
    chk("single_key", 32'(bus.KEY), 5);

    // bounce on channel 9
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      cyc(SCN);
    end
    keys = 16'h0200;
    cyc(5*SCN);
    chk("bounce_snap", 32'(bus.SNAP), 32'h0200);
    chk("bounce_key", 32'(bus.KEY), 9);

    // multi-key and roll-over
    keys = 16'h1008;
    cyc(5*SCN);
    chk("multi_snap", 32'(bus.SNAP), 32'h1008);
    chk("multi_key", 32'(bus.KEY), 3);
    keys = 16'h1000;
    v0 = vcount;
    cyc(5*SCN);
    chk("roll_valid_cnt", 32'(vcount - v0), 1);
    chk("roll_key", 32'(bus.KEY), 12);
    keys = 16'h0000;
    v0 = vcount;
    cyc(5*SCN);
    chk("rel_valid_cnt", 32'(vcount - v0), 0);
    chk("rel_key", 32'(bus.KEY), 12);
    chk("rel_held", 32'(bus.HELD), 0);

    // EN drop mid-scan
    keys = 16'h0004;
    cyc(SCN + 8);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.SEL == 4'd7) begin found = 1; break; end
    end
    chk("sel7_reached", 32'(found), 1);
    en = 0;
    cyc(1);
    chk("drop_sel", 32'(bus.SEL), 0);
    cyc(4);
    en = 1;
    v0 = vcount;
    cyc(3*SCN);
    chk("reen_early_cnt", 32'(vcount - v0), 0);
    cyc(2*SCN);
    chk("reen_key", 32'(bus.KEY), 2);

    // reset mid-operation
    keys = 16'h0020;
    cyc(5*SCN);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("rst_snap", 32'(bus.SNAP), 0);
    chk("rst_key", 32'(bus.KEY), 0);
    chk("rst_held", 32'(bus.HELD), 0);
    cyc(5*SCN);

    // random phase
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       keys = 16'h0000;
        1:       keys = 16'(1 << $urandom_range(0, 15));
        2:       keys = 16'(1 << $urandom_range(0, 15))
                      | 16'(1 << $urandom_range(0, 15));
        default: keys = 16'($urandom);
      endcase
      cyc($urandom_range(20, 400));
      if ($urandom_range(0, 4) == 0) begin
        en = 0;
        cyc($urandom_range(1, 5));
        en = 1;
      end
      if ($urandom_range(0, 7) == 0) begin
        rst = 1;
        cyc(1);
        rst = 0;
      end
    end
    cyc(2);
    chk("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
